// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one variable-latency memory port between instruction
//            fetch and data access. Round-robin on ties, byte-enable stores,
//            sign-extended byte loads, misalignment and timeout errors.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic        i_err,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    // memory side
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [29:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic       C_PORT_FETCH = 1'b0;
    localparam logic       C_PORT_DATA  = 1'b1;
    localparam logic [7:0] C_LAST_WAIT  = 8'(MAX_WAIT - 1);

    state_t      state_q,      state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q,      grant_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic        m_req_q,      m_req_d;
    logic        m_we_q,       m_we_d;
    logic [3:0]  m_be_q,       m_be_d;
    logic [29:0] m_addr_q,     m_addr_d;
    logic [31:0] m_wdata_q,    m_wdata_d;
    logic [31:0] rdata_q,      rdata_d;
    logic        err_q,        err_d;
    logic        txn_byte_q,   txn_byte_d;
    logic [1:0]  txn_off_q,    txn_off_d;

    // request decoding for the port that would be granted this cycle
    logic        w_sel;
    logic        w_misaligned;
    logic        w_we;
    logic        w_byte;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [29:0] w_addr;
    logic [31:0] w_wdata;
    logic [7:0]  w_rbyte;
    logic [31:0] w_load_data;

    // Pick the winner (tie goes to the port not granted last) and form its memory command
    always_comb begin
        w_sel        = C_PORT_FETCH;
        w_misaligned = 1'b0;
        w_we         = 1'b0;
        w_byte       = 1'b0;
        w_off        = 2'b00;
        w_be         = 4'hF;
        w_addr       = i_addr[31:2];
        w_wdata      = 32'd0;
        if (i_req && d_req) begin
            w_sel = ~last_grant_q;
        end else if (d_req) begin
            w_sel = C_PORT_DATA;
        end
        if (w_sel == C_PORT_FETCH) begin
            w_misaligned = (i_addr[1:0] != 2'b00);
        end else begin
            w_misaligned = !d_byte && (d_addr[1:0] != 2'b00);
            w_we         = d_we;
            w_byte       = d_byte;
            w_off        = d_addr[1:0];
            w_addr       = d_addr[31:2];
            if (d_byte && d_we) begin
                w_be    = 4'b0001 << d_addr[1:0];
                w_wdata = {4{d_wdata[7:0]}};
            end else begin
                w_wdata = d_wdata;
            end
        end
    end

    // Extract the addressed byte of the returning word and form the load result
    always_comb begin
        w_rbyte = m_rdata[7:0];
        case (txn_off_q)
            2'd1:    w_rbyte = m_rdata[15:8];
            2'd2:    w_rbyte = m_rdata[23:16];
            2'd3:    w_rbyte = m_rdata[31:24];
            default: w_rbyte = m_rdata[7:0];
        endcase
        if (m_we_q) begin
            w_load_data = 32'd0;
        end else if (txn_byte_q) begin
            w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
        end else begin
            w_load_data = m_rdata;
        end
    end

    // Next-state logic: grant, wait for ack or timeout, then one response cycle
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_be_d       = m_be_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        txn_byte_d   = txn_byte_q;
        txn_off_d    = txn_off_q;
        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    grant_d      = w_sel;
                    last_grant_d = w_sel;
                    if (w_misaligned) begin
                        // no memory cycle: report the error straight away
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_RESP;
                    end else begin
                        m_req_d    = 1'b1;
                        m_we_d     = w_we;
                        m_be_d     = w_be;
                        m_addr_d   = w_addr;
                        m_wdata_d  = w_wdata;
                        txn_byte_d = w_byte;
                        txn_off_d  = w_off;
                        cnt_d      = 8'd0;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (m_ack) begin
                    // ack takes priority over a simultaneous timeout
                    m_req_d = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = w_load_data;
                    state_d = S_RESP;
                end else if (cnt_q == C_LAST_WAIT) begin
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                rdata_d = 32'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= C_PORT_DATA;
            grant_q      <= C_PORT_FETCH;
            cnt_q        <= 8'd0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_be_q       <= 4'h0;
            m_addr_q     <= 30'd0;
            m_wdata_q    <= 32'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            txn_byte_q   <= 1'b0;
            txn_off_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_be_q       <= m_be_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            txn_byte_q   <= txn_byte_d;
            txn_off_q    <= txn_off_d;
        end
    end

    // Completion outputs are live only in the response cycle, on the granted port
    always_comb begin
        i_done  = (state_q == S_RESP) && (grant_q == C_PORT_FETCH);
        d_done  = (state_q == S_RESP) && (grant_q == C_PORT_DATA);
        i_err   = i_done && err_q;
        d_err   = d_done && err_q;
        i_rdata = i_done ? rdata_q : 32'd0;
        d_rdata = d_done ? rdata_q : 32'd0;
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter with a
//            programmable-latency memory responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic        d_byte;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    mem_port_arbiter #(.MAX_WAIT(4)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_done  (i_done),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_byte  (d_byte),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_done  (d_done),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_be    (m_be),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // memory model: acks after mem_lat idle cycles of m_req (mem_lat < 0: never)
    int          mem_lat = 0;
    logic [31:0] mem_val = 32'd0;
    int          wcnt    = 0;
    localparam logic [31:0] C_JUNK = 32'hBAD0BAD0;

    initial begin
        m_ack   = 1'b0;
        m_rdata = C_JUNK;
        forever begin
            @(negedge clk);
            if (m_req && !reset) begin
                if (mem_lat >= 0 && wcnt == mem_lat) begin
                    m_ack   = 1'b1;
                    m_rdata = mem_val;
                end else begin
                    m_ack   = 1'b0;
                    m_rdata = C_JUNK;
                end
                wcnt++;
            end else begin
                m_ack   = 1'b0;
                m_rdata = C_JUNK;
                wcnt    = 0;
            end
        end
    end

    // per-transaction observations
    logic [31:0] r_rdata, r_wdata, r_addr;
    logic [3:0]  r_be;
    logic        r_err, r_we;
    int          r_k, r_mreq_n, r_pulses, r_other;

    task automatic txn(input bit is_data, input bit we, input bit bt,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int lat, input logic [31:0] val);
        mem_lat  = lat;
        mem_val  = val;
        r_k      = 0;
        r_mreq_n = 0;
        r_pulses = 0;
        r_other  = 0;
        r_rdata  = 32'hFFFF_FFFF;
        r_err    = 1'bx;
        r_be     = 4'h0;
        r_wdata  = 32'd0;
        r_addr   = 32'd0;
        r_we     = 1'b0;
        @(negedge clk);
        if (is_data) begin
            d_we = we; d_byte = bt; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        for (int k = 1; k <= 20 && r_pulses == 0; k++) begin
            @(negedge clk);
            if (m_req) begin
                if (r_mreq_n == 0) begin
                    r_be = m_be; r_wdata = m_wdata; r_addr = {2'b00, m_addr}; r_we = m_we;
                end
                r_mreq_n++;
            end
            if (is_data ? d_done : i_done) begin
                r_pulses++;
                r_k     = k;
                r_rdata = is_data ? d_rdata : i_rdata;
                r_err   = is_data ? d_err : i_err;
                i_req   = 1'b0;
                d_req   = 1'b0;
            end
            if (is_data ? i_done : d_done) r_other++;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (is_data ? d_done : i_done) r_pulses++;
            if (is_data ? i_done : d_done) r_other++;
        end
    endtask

    int ord [4];
    int n_g;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h0000_0200; d_wdata = 32'd0;
        mem_lat = 0; mem_val = 32'h1357_9BDF;
        repeat (2) @(negedge clk);
        chk("rst.ctl",   {25'd0, m_req, m_we, i_done, d_done, i_err, d_err, 1'b0}, 32'd0);
        chk("rst.be",    {28'd0, m_be}, 32'd0);
        chk("rst.maddr", {2'b00, m_addr}, 32'd0);
        chk("rst.rdata", i_rdata | d_rdata | m_wdata, 32'd0);

        // both requests held across reset exit: fetch first, then alternate
        reset = 1'b0;
        n_g = 0;
        for (int k = 0; k < 40 && n_g < 4; k++) begin
            @(negedge clk);
            if (i_done && d_done) begin
                chk("arb.both_done", 32'd1, 32'd0);
                n_g = 4;
            end else if (i_done) begin
                ord[n_g] = 0;
                if (n_g == 0) chk("arb.i_rdata", i_rdata, 32'h1357_9BDF);
                n_g++;
            end else if (d_done) begin
                ord[n_g] = 1;
                n_g++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("arb.count", n_g, 4);
        chk("arb.g0", ord[0], 0);
        chk("arb.g1", ord[1], 1);
        chk("arb.g2", ord[2], 0);
        chk("arb.g3", ord[3], 1);
        repeat (2) @(negedge clk);

        // fetch, memory acks on the third cycle of m_req
        txn(1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'd0, 2, 32'h3C01_ABCD);
        chk("fet.maddr",  r_addr, 32'h0000_0C00);
        chk("fet.be",     {28'd0, r_be}, 32'hF);
        chk("fet.we",     {31'd0, r_we}, 32'd0);
        chk("fet.rdata",  r_rdata, 32'h3C01_ABCD);
        chk("fet.err",    {31'd0, r_err}, 32'd0);
        chk("fet.pulses", r_pulses, 1);
        chk("fet.other",  r_other, 0);
        chk("fet.lat",    r_k, 4);

        // sb 0x1002
        txn(1'b1, 1'b1, 1'b1, 32'h0000_1002, 32'h0000_00A5, 0, 32'h0);
        chk("sb.be",     {28'd0, r_be}, 32'h4);
        chk("sb.wdata",  r_wdata, 32'hA5A5_A5A5);
        chk("sb.we",     {31'd0, r_we}, 32'd1);
        chk("sb.maddr",  r_addr, 32'h0000_0400);
        chk("sb.rdata",  r_rdata, 32'd0);
        chk("sb.lat",    r_k, 2);
        chk("sb.other",  r_other, 0);

        // lb 0x1002, negative byte
        txn(1'b1, 1'b0, 1'b1, 32'h0000_1002, 32'd0, 1, 32'h0080_FF00);
        chk("lb2.rdata", r_rdata, 32'hFFFF_FF80);
        chk("lb2.be",    {28'd0, r_be}, 32'hF);
        chk("lb2.err",   {31'd0, r_err}, 32'd0);

        // lw misaligned
        txn(1'b1, 1'b0, 1'b0, 32'h0000_1001, 32'd0, 0, 32'h1111_1111);
        chk("lwmis.err",  {31'd0, r_err}, 32'd1);
        chk("lwmis.rd",   r_rdata, 32'd0);
        chk("lwmis.mreq", r_mreq_n, 0);
        chk("lwmis.lat",  r_k, 1);
        chk("lwmis.puls", r_pulses, 1);

        // lb 0x1001 is legal, positive byte
        txn(1'b1, 1'b0, 1'b1, 32'h0000_1001, 32'd0, 0, 32'h0000_1234);
        chk("lb1.rdata", r_rdata, 32'h0000_0012);
        chk("lb1.err",   {31'd0, r_err}, 32'd0);
        chk("lb1.mreq",  r_mreq_n, 1);

        // sw / lw word accesses
        txn(1'b1, 1'b1, 1'b0, 32'h0000_2008, 32'h1234_5678, 0, 32'h0);
        chk("sw.wdata", r_wdata, 32'h1234_5678);
        chk("sw.be",    {28'd0, r_be}, 32'hF);
        chk("sw.maddr", r_addr, 32'h0000_0802);
        txn(1'b1, 1'b0, 1'b0, 32'h0000_2004, 32'd0, 1, 32'hDEAD_BEEF);
        chk("lw.rdata", r_rdata, 32'hDEAD_BEEF);
        chk("lw.we",    {31'd0, r_we}, 32'd0);

        // misaligned fetch
        txn(1'b0, 1'b0, 1'b0, 32'h0000_3002, 32'd0, 0, 32'h2222_2222);
        chk("fmis.err", {31'd0, r_err}, 32'd1);
        chk("fmis.lat", r_k, 1);
        chk("fmis.rd",  r_rdata, 32'd0);

        // timeout: never acked
        txn(1'b0, 1'b0, 1'b0, 32'h0000_4000, 32'd0, -1, 32'h0);
        chk("tmo.mreq", r_mreq_n, 4);
        chk("tmo.lat",  r_k, 5);
        chk("tmo.err",  {31'd0, r_err}, 32'd1);
        chk("tmo.rd",   r_rdata, 32'd0);

        // ack lands on the expiry cycle
        txn(1'b0, 1'b0, 1'b0, 32'h0000_4000, 32'd0, 3, 32'h55AA_55AA);
        chk("exp.mreq", r_mreq_n, 4);
        chk("exp.err",  {31'd0, r_err}, 32'd0);
        chk("exp.rd",   r_rdata, 32'h55AA_55AA);

        // reset during WAIT aborts without a done pulse
        mem_lat = -1;
        @(negedge clk);
        i_addr = 32'h0000_5000; i_req = 1'b1;
        @(negedge clk);
        chk("rw.mreq_up", {31'd0, m_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rw.mreq_dn", {31'd0, m_req}, 32'd0);
        r_pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (i_done || d_done) r_pulses++;
        end
        i_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        if (i_done || d_done) r_pulses++;
        chk("rw.nodone", r_pulses, 0);
        txn(1'b0, 1'b0, 1'b0, 32'h0000_6000, 32'd0, 0, 32'h0000_CAFE);
        chk("rw.next_rd",  r_rdata, 32'h0000_CAFE);
        chk("rw.next_lat", r_k, 2);
        chk("rw.next_pul", r_pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory of the multicycle MIPS core between the instruction-fetch path (fetch state) and the data path (lw/sw/lb/sb states).
- Arbitrates between the two requesters with round-robin priority on ties.
- Runs a req/ack handshake with variable-latency memory and converts byte accesses into byte-enable writes and sign-extended reads.
- Flags misaligned accesses and memory timeouts so the controller can stall or trap.

Parameters:
- MAX_WAIT, 255: cycles to wait for m_ack before aborting; range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request; held until i_done
- i_addr  in  32  fetch byte address
- i_rdata  out  32  fetched word; valid while i_done=1
- i_done  out  1  one-cycle completion pulse, fetch port
- i_err  out  1  fetch error, qualified by i_done
- d_req  in  1  data request; held until d_done
- d_we  in  1  1=store, 0=load
- d_byte  in  1  1=byte access (lb/sb), 0=word
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load result; valid while d_done=1
- d_done  out  1  one-cycle completion pulse, data port
- d_err  out  1  data error, qualified by d_done
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable
- m_be  out  4  byte enables; bit k = bits 8k+7:8k
- m_addr  out  30  word address (byte address [31:2])
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data; sampled when m_ack=1
- m_ack  in  1  memory completion, one cycle, only while m_req=1

Behaviour:
- Reset values: all outputs 0, state IDLE, wait counter 0, last_grant=DATA (so the first tie goes to fetch). Asserting reset mid-transaction aborts it immediately. No done pulse is produced.
- Requester rules: addr/we/byte/wdata stay stable while req=1. Req drops at the clock edge ending the done cycle. Req sampled high during RESP or after done is not a new request.
- FSM states: IDLE, WAIT, RESP.
- IDLE, no req: stay.
- IDLE, one req: grant that port.
- IDLE, both reqs: grant the port that is not last_grant. Update last_grant on every grant.
- Grant with misalignment: fetch with i_addr[1:0]!=0, or data word access with d_addr[1:0]!=0. No memory cycle; go to RESP with err=1 and rdata=0.
- Grant, aligned: latch m_addr, m_we (0 for fetch), m_be, m_wdata. Set m_req=1, clear the counter, go to WAIT.
- m_be/m_wdata encoding: word access gives m_be=4'hF and m_wdata=d_wdata. Byte store gives m_be=1<<d_addr[1:0] and m_wdata={4{d_wdata[7:0]}}. Loads and fetches give m_be=4'hF.
- WAIT, m_ack=1: capture the read result, m_req=0, go to RESP with err=0. Byte load result = sign-extend of byte d_addr[1:0] of m_rdata (byte 0 = bits 7:0). Word result = m_rdata. Stores return rdata=0.
- WAIT, no ack: increment the counter. When the counter reaches MAX_WAIT-1 without ack: m_req=0, go to RESP with err=1, rdata=0. If ack and expiry fall in the same cycle, ack wins.
- RESP: pulse done for the granted port only, with rdata/err valid. Go to IDLE. done/err/rdata are 0 in every other cycle.
- m_ack outside WAIT is ignored.
- Latency: req seen in IDLE at cycle N gives m_req high at N+1. Ack at cycle M gives done at M+1. Minimum is done at N+2 (zero-wait memory acking at N+1). A misaligned access gives done at N+1.
- Back-to-back: after RESP there is one IDLE cycle before the next grant.
- Throughput: at most one transaction in flight.

Test Plan:
- Fetch i_addr=0x00003000, memory acks after 3 cycles with 0x3C01ABCD -> m_addr=0x00000C00, m_be=F, m_we=0; i_done pulses exactly once with i_rdata=0x3C01ABCD, i_err=0.
- Fetch and load both requested at reset-exit -> fetch granted first, then data; with both held continuously, grants alternate I,D,I,D.
- sb d_addr=0x1002, d_wdata=0x000000A5 -> m_be=4'b0100, m_wdata=0xA5A5A5A5, m_we=1; d_done with d_rdata=0. lb same address, m_rdata=0x0080FF00 -> d_rdata=0xFFFFFF80.
- lw d_addr=0x1001 -> no m_req; d_done on the next cycle with d_err=1. lb d_addr=0x1001 proceeds normally.
- MAX_WAIT=4, m_ack never asserted -> m_req drops after 4 cycles; done pulses with err=1, rdata=0. Repeat with ack on the expiry cycle -> err=0.
- Reset asserted during WAIT -> m_req=0 and state IDLE immediately; no done pulse; the next request completes normally.
